// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the single-cycle core.
// Owns the D-bit fetch address and sequences start, stall, taken branches
// (with a one-cycle flush indication) and halt.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   start        begin execution (sampled only in IDLE/HALTED)
//   stall        freeze PC, FSM and flush this cycle (RUN only)
//   branch_en    current instruction is a branch
//   branch_take  branch condition true (ignored unless branch_en)
//   branch_idx   LUT index for the branch target
//   halt_req     current instruction is the halt instruction
//   lut_addr     index to the branch-target LUT (copy of branch_idx)
//   lut_target   absolute target returned by the LUT, same cycle
//   prog_ctr     current fetch address (registered)
//   flush        high for one cycle after a taken branch (registered)
//   busy         high in RUN
//   done         high in HALTED
module pc_sequencer #(
    parameter int unsigned D        = 10,
    parameter int unsigned A        = 4,
    parameter logic [D-1:0] START_PC = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stall,
    input  logic         branch_en,
    input  logic         branch_take,
    input  logic [A-1:0] branch_idx,
    input  logic         halt_req,
    output logic [A-1:0] lut_addr,
    input  logic [D-1:0] lut_target,
    output logic [D-1:0] prog_ctr,
    output logic         flush,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;

    // LUT is addressed directly from the decoder, independent of state.
    assign lut_addr = branch_idx;

    // busy/done are registered alongside state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            prog_ctr <= START_PC;
            flush    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state    <= RUN;
                        prog_ctr <= START_PC;
                        flush    <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    // Stalled cycles leave everything untouched, so a pending
                    // branch or halt is simply re-evaluated after the stall.
                    if (!stall) begin
                        if (halt_req) begin
                            state <= HALTED;
                            flush <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (branch_en && branch_take) begin
                            prog_ctr <= lut_target;
                            flush    <= 1'b1;
                        end else begin
                            prog_ctr <= prog_ctr + D'(1);
                            flush    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    prog_ctr <= START_PC;
                    flush    <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the single-cycle core; owns the D-bit program counter and sequences instruction fetch.
- Drives the 4-bit index into the branch-target lookup table (PC_LUT) and consumes its combinational D-bit target.
- Handles start, stall, taken branches (with a one-cycle flush indication) and halt.
- Sits between the decoder/condition logic and instruction memory.

Parameters:
- D, 10, program counter / branch target width.
- A, 4, branch-target LUT index width.
- START_PC, 0, PC value loaded on every start.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  begin execution; level, sampled only in IDLE/HALTED.
- stall  in  1  freeze PC and FSM this cycle.
- branch_en  in  1  current instruction is a branch.
- branch_take  in  1  branch condition true; ignored unless branch_en.
- branch_idx  in  A  LUT index for the branch target.
- halt_req  in  1  current instruction is the end/halt instruction.
- lut_addr  out  A  index to the target LUT; combinational copy of branch_idx.
- lut_target  in  D  target returned by the LUT, same cycle.
- prog_ctr  out  D  current fetch address (registered).
- flush  out  1  registered; high for one cycle after a taken branch.
- busy  out  1  high in RUN.
- done  out  1  high in HALTED.

Behaviour:
- FSM states: IDLE, RUN, HALTED.
- Reset (reset_n=0 at clk edge), regardless of state or in-flight branch:
  - state=IDLE, prog_ctr=START_PC, flush=0, busy=0, done=0.
- IDLE:
  - prog_ctr held; busy=0, done=0.
  - start=1 -> RUN next cycle; prog_ctr=START_PC.
- RUN, evaluated each edge in strict priority:
  1. stall=1: prog_ctr, state and flush all hold. A branch or halt presented during a stall is not acted on; it is re-evaluated once stall drops.
  2. halt_req=1: state -> HALTED, prog_ctr holds. halt_req beats a simultaneous taken branch.
  3. branch_en & branch_take: prog_ctr <= lut_target, flush <= 1. Target equal to current PC is legal (self-loop). Back-to-back taken branches each redirect and each pulse flush.
  4. Otherwise: prog_ctr <= prog_ctr + 1, modulo 2^D. 2^D-1 wraps to 0 with no flag.
- flush:
  - Cleared on any non-stalled RUN edge without a taken branch.
  - Held through stalls.
  - Forced to 0 on entering HALTED.
- Latency: a taken branch presented in cycle n gives prog_ctr = target in cycle n+1. No extra bubble is inserted by this block; flush only tells fetch to squash.
- HALTED:
  - done=1, busy=0, prog_ctr holds the halt address.
  - start=1 -> RUN with prog_ctr=START_PC, done drops the next cycle.
  - stall is ignored in IDLE/HALTED.
- lut_addr = branch_idx at all times, independent of state. The LUT is read-only from this block.
- Arithmetic: D-bit unsigned; lut_target is used as an absolute address, never added to PC.
- Unmapped LUT entries are X; the block passes them through. Verification treats any X on prog_ctr as a failure only if a branch with a mapped index was expected.

Test Plan:
- Reset then start=1 for one cycle, no branches -> prog_ctr goes 0,1,2,3,… each cycle; busy=1; flush=0.
- In RUN at PC=5, branch_en=1, branch_take=1, branch_idx=2 (LUT returns 81) -> next cycle prog_ctr=81, flush=1 for exactly one cycle, then 82.
- branch_en=1, branch_take=0 at PC=9 -> PC=10, flush stays 0.
- Stall 3 cycles at PC=20 with a taken branch (idx=4, target 120) held on the inputs -> PC=20 throughout the stall; first unstalled cycle -> PC=120, flush=1.
- halt_req=1 and a taken branch together at PC=120 -> HALTED, done=1, PC=120 held; a later start=1 -> PC=0, busy=1.
- Wrap test: force PC to 1023 via a branch (LUT entry 1023), no further branch -> PC=0. Then reset_n=0 mid-RUN with a taken branch -> IDLE, PC=0, flush=0.
